pipe_reg_chain: RTL

- Parametrised, elastic register pipeline: WIDTH-bit data carried through DEPTH register stages, with a valid/ready handshake on each side.
- Successor to the plain single-bit D flip-flop. Adds vector width, depth, per-stage valid tracking, back-pressure with bubble collapsing, a pipeline flush and an occupancy count.
- Used to delay and retime branch-metric and decision words between the Viterbi ACS and traceback units.

---
 rtl/pipe_reg_chain_pkg.sv | 27 ++
 rtl/pipe_reg_chain_stage.sv | 45 ++++
 rtl/pipe_reg_chain.sv | 63 ++++++
 3 files changed

// File: rtl/pipe_reg_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_pkg
// Brief    : Shared constants and helpers for the Viterbi retiming pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package viterbi_pkg;

  localparam int unsigned VITERBI_WORD_W = 8;
  // Widest valid vector popcount() can count; chains must keep DEPTH at or below this.
  localparam int unsigned POP_MAX_W      = 64;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] bits);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n = n + {31'b0, bits[i]};
    end
    return n;
  endfunction

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_reg_chain_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_reg_stage
// Brief    : One elastic register stage with bubble-collapsing ready.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_reg_stage #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             v,
  output logic [WIDTH-1:0] d,
  output logic             rdy
);

  logic             r_v;
  logic [WIDTH-1:0] r_d;

  // An empty stage always accepts, so bubbles close up behind a stall.
  assign rdy = !r_v || down_ready;
  assign v   = r_v;
  assign d   = r_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_v <= 1'b0;
      r_d <= RESET_DATA;
    end else if (Flush) begin
      r_v <= 1'b0;
    end else if (rdy) begin
      r_v <= up_valid;
      if (up_valid) begin
        r_d <= up_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_reg_chain.sv
`default_nettype none
// ============================================================================
// Module   : pipe_reg_chain
// Brief    : DEPTH-stage elastic register pipeline with flush and occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_reg_chain
  import viterbi_pkg::*;
#(
  parameter int unsigned      WIDTH      = VITERBI_WORD_W,
  parameter int unsigned      DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic                            Flush,
  input  logic                            InValid,
  output logic                            InReady,
  input  logic [WIDTH-1:0]                InData,
  output logic                            OutValid,
  input  logic                            OutReady,
  output logic [WIDTH-1:0]                OutData,
  output logic [occ_width(DEPTH)-1:0]     Occupancy
);

  localparam int unsigned OCC_W = occ_width(DEPTH);

  // Index 0 is the upstream port; index i+1 is the output of stage i.
  logic [DEPTH:0]   w_vld;
  logic [WIDTH-1:0] w_dat [DEPTH+1];
  // Index i is stage i's ready; index DEPTH is the downstream ready.
  logic [DEPTH:0]   w_rdy;
  logic [POP_MAX_W-1:0] w_vbits;

  assign w_vld[0]     = InValid;
  assign w_dat[0]     = InData;
  assign w_rdy[DEPTH] = OutReady;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_reg_stage #(
      .WIDTH      (WIDTH),
      .RESET_DATA (RESET_DATA)
    ) u_stage (
      .Clock      (Clock),
      .Reset      (Reset),
      .Flush      (Flush),
      .up_valid   (w_vld[i]),
      .up_data    (w_dat[i]),
      .down_ready (w_rdy[i+1]),
      .v          (w_vld[i+1]),
      .d          (w_dat[i+1]),
      .rdy        (w_rdy[i])
    );
  end

  assign InReady   = w_rdy[0] && !Flush;
  assign OutValid  = w_vld[DEPTH];
  assign OutData   = w_dat[DEPTH];
  assign w_vbits   = POP_MAX_W'(w_vld[DEPTH:1]);
  assign Occupancy = OCC_W'(popcount(w_vbits));

endmodule
`default_nettype wire
